wb_trace_checker: RTL and testbench
===================================

Name: wb_trace_checker

Overview:
- Consumer of the CPU core's writeback trace port (debug_wb_pc / rf_we / rf_wnum / rf_wdata).
- Holds a FIFO of golden writeback records, loaded through a valid/ready push port, and compares each retired register write against the FIFO head.
- Counts matches, latches the first mismatch, and reports pass/fail.
- Sits beside mycpu_top in the SoC-lite environment, driven by the same clk.

Parameters:
DEPTH, 16, golden FIFO entries; power of two, >= 2
END_PC, 32'h1c00_0100, PC whose observation ends the run

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
debug_wb_pc  in  32  PC of the retiring instruction
debug_wb_rf_we  in  4  byte write enables of the register write
debug_wb_rf_wnum  in  5  destination register number
debug_wb_rf_wdata  in  32  register write data
gold_valid  in  1  golden record offered
gold_ready  out  1  FIFO can accept a record
gold_pc  in  32  expected PC
gold_wnum  in  5  expected register number
gold_wdata  in  32  expected data
pass_cnt  out  32  number of matched events
fail  out  1  sticky mismatch or underflow flag
done  out  1  sticky end-of-test flag
err_pc  out  32  DUT PC at the first error
err_exp_pc  out  32  golden PC at the first error (0 on underflow)
err_wnum  out  5  DUT wnum at the first error
err_wdata  out  32  DUT wdata at the first error

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high.
- Reset values:
  - All outputs 0, except gold_ready = 1.
  - FIFO empty; state RUN.
- FIFO:
  - Read and write pointers are log2(DEPTH)+1 bits wide.
  - full when the pointer MSBs differ and the remaining bits are equal; empty when the pointers are equal.
  - gold_ready = ~full, derived from registered pointers only.
  - Push occurs on gold_valid & gold_ready.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - When full, a push is refused even if a pop happens that same cycle.
  - No bypass: a record pushed in cycle N is poppable from cycle N+1.
- Event: debug_wb_rf_we != 0 and debug_wb_rf_wnum != 0. Writes to r0 are ignored and pop nothing.
- Compare:
  - Match requires pc == gold_pc, wnum == gold_wnum, and, for each byte i with we[i]=1, wdata[8i+7:8i] == gold_wdata[8i+7:8i].
  - Bytes with we[i]=0 are don't-care.
- State machine. State encoding: RUN=0, FAIL=1, PASS=2.
  - RUN, event with FIFO non-empty:
    - Pop the head.
    - On match, pass_cnt increments the following cycle, wrapping modulo 2^32.
    - On mismatch, go to FAIL; the err_* registers capture DUT values and err_exp_pc = gold_pc.
  - RUN, event with FIFO empty (underflow): go to FAIL; capture DUT values, err_exp_pc = 0.
  - RUN, debug_wb_pc == END_PC:
    - Go to PASS and set done.
    - If an event occurs in the same cycle, it is checked first. A mismatch or underflow wins: go to FAIL and set done.
  - FAIL:
    - fail=1 is sticky.
    - Events are ignored; no pops, and pass_cnt is frozen.
    - Pushes are still accepted while not full.
    - done is set when END_PC is observed.
  - PASS: terminal. Events are ignored and pass_cnt is frozen.
- Output latency: all outputs are registered. fail, done, pass_cnt and err_* update 1 cycle after the triggering input cycle.
- err_* are written only on the RUN->FAIL transition and never overwritten afterwards.
- Back-to-back events on consecutive cycles are supported, with one pop per cycle.
- Reset mid-run: empties the FIFO, clears all flags and counters, and restores state RUN.

Test Plan:
- Push 3 records {1c000000,r4,0x11}, {1c000004,r5,0x22}, {1c000008,r6,0x33}; drive 3 matching events with we=4'hf -> pass_cnt=3, fail=0, FIFO empty.
- Push {1c000000,r4,0x12345678}; event pc=1c000000, r4, wdata=0x12FF5678, we=4'hf -> next cycle fail=1, err_pc=1c000000, err_exp_pc=1c000000, err_wdata=0x12FF5678, pass_cnt=0.
- Same record, event wdata=0xAB345678 with we=4'b0111 -> match (byte 3 masked), pass_cnt=1.
- Empty FIFO, event pc=1c000010, r7 -> fail=1, err_exp_pc=0, err_wnum=7; a later event leaves err_* unchanged.
- Push DEPTH records without events -> gold_ready=0 after the DEPTH-th push. Event and push in the same full cycle -> the push is refused; gold_ready=1 the next cycle.
- An event with wnum=0 pops nothing and pass_cnt is unchanged. debug_wb_pc=END_PC -> done=1, fail=0. Asserting reset afterwards -> all outputs 0, gold_ready=1.

Source files
------------

// File: rtl/wb_trace_checker.sv
// Writeback trace checker: compares each retired register write against a FIFO of golden
// records, counts matches, latches the first error and flags pass/fail/done.
module wb_trace_checker #(
    parameter int          DEPTH  = 16,
    parameter logic [31:0] END_PC = 32'h1c00_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_we,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic        gold_valid,
    output logic        gold_ready,
    input  logic [31:0] gold_pc,
    input  logic [4:0]  gold_wnum,
    input  logic [31:0] gold_wdata,
    output logic [31:0] pass_cnt,
    output logic        fail,
    output logic        done,
    output logic [31:0] err_pc,
    output logic [31:0] err_exp_pc,
    output logic [4:0]  err_wnum,
    output logic [31:0] err_wdata
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_FAIL = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] pass_cnt_q, pass_cnt_d;
    logic        fail_q, fail_d;
    logic        done_q, done_d;
    logic [31:0] err_pc_q, err_pc_d;
    logic [31:0] err_exp_pc_q, err_exp_pc_d;
    logic [4:0]  err_wnum_q, err_wnum_d;
    logic [31:0] err_wdata_q, err_wdata_d;

    logic [31:0] mem_pc_q    [DEPTH];
    logic [4:0]  mem_wnum_q  [DEPTH];
    logic [31:0] mem_wdata_q [DEPTH];

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        go_fail;
    logic        wb_event;
    logic        end_seen;
    logic        head_match;
    logic [31:0] head_pc;
    logic [4:0]  head_wnum;
    logic [31:0] head_wdata;
    logic [31:0] byte_mask;

    // Extra pointer MSB distinguishes full from empty when the index bits coincide.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = gold_valid & ~full;

    assign head_pc    = mem_pc_q[rd_ptr_q[AW-1:0]];
    assign head_wnum  = mem_wnum_q[rd_ptr_q[AW-1:0]];
    assign head_wdata = mem_wdata_q[rd_ptr_q[AW-1:0]];

    assign wb_event = (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    assign end_seen = (debug_wb_pc == END_PC);

    // Bytes not written by the core are don't-care in the data compare.
    assign byte_mask = {{8{debug_wb_rf_we[3]}}, {8{debug_wb_rf_we[2]}},
                        {8{debug_wb_rf_we[1]}}, {8{debug_wb_rf_we[0]}}};
    assign head_match = (debug_wb_pc == head_pc) && (debug_wb_rf_wnum == head_wnum) &&
                        (((debug_wb_rf_wdata ^ head_wdata) & byte_mask) == 32'd0);

    always_comb begin
        state_d      = state_q;
        pass_cnt_d   = pass_cnt_q;
        fail_d       = fail_q;
        done_d       = done_q;
        err_pc_d     = err_pc_q;
        err_exp_pc_d = err_exp_pc_q;
        err_wnum_d   = err_wnum_q;
        err_wdata_d  = err_wdata_q;
        pop          = 1'b0;
        go_fail      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (wb_event) begin
                    if (!empty) begin
                        pop = 1'b1;
                        if (head_match) begin
                            pass_cnt_d = pass_cnt_q + 32'd1;
                        end else begin
                            go_fail      = 1'b1;
                            err_exp_pc_d = head_pc;
                        end
                    end else begin
                        go_fail      = 1'b1;
                        err_exp_pc_d = 32'd0;
                    end
                end
                // A failing event in the END_PC cycle takes priority over passing.
                if (go_fail) begin
                    state_d     = ST_FAIL;
                    fail_d      = 1'b1;
                    err_pc_d    = debug_wb_pc;
                    err_wnum_d  = debug_wb_rf_wnum;
                    err_wdata_d = debug_wb_rf_wdata;
                    if (end_seen) begin
                        done_d = 1'b1;
                    end
                end else if (end_seen) begin
                    state_d = ST_PASS;
                    done_d  = 1'b1;
                end
            end
            ST_FAIL: begin
                if (end_seen) begin
                    done_d = 1'b1;
                end
            end
            ST_PASS: begin
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pass_cnt_q   <= 32'd0;
            fail_q       <= 1'b0;
            done_q       <= 1'b0;
            err_pc_q     <= 32'd0;
            err_exp_pc_q <= 32'd0;
            err_wnum_q   <= 5'd0;
            err_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_q       <= fail_d;
            done_q       <= done_d;
            err_pc_q     <= err_pc_d;
            err_exp_pc_q <= err_exp_pc_d;
            err_wnum_q   <= err_wnum_d;
            err_wdata_q  <= err_wdata_d;
        end
    end

    // Storage needs no reset: contents are only read behind a valid pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q[AW-1:0]]    <= gold_pc;
            mem_wnum_q[wr_ptr_q[AW-1:0]]  <= gold_wnum;
            mem_wdata_q[wr_ptr_q[AW-1:0]] <= gold_wdata;
        end
    end

    assign gold_ready = ~full;
    assign pass_cnt   = pass_cnt_q;
    assign fail       = fail_q;
    assign done       = done_q;
    assign err_pc     = err_pc_q;
    assign err_exp_pc = err_exp_pc_q;
    assign err_wnum   = err_wnum_q;
    assign err_wdata  = err_wdata_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench for wb_trace_checker: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the golden FIFO and pass/fail bookkeeping.
module tb_wb_trace_checker;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] END_PC = 32'h1c00_0100;
    localparam logic [31:0] BASE   = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] debug_wb_pc = '0;
    logic [3:0]  debug_wb_rf_we = '0;
    logic [4:0]  debug_wb_rf_wnum = '0;
    logic [31:0] debug_wb_rf_wdata = '0;
    logic        gold_valid = 1'b0;
    logic        gold_ready;
    logic [31:0] gold_pc = '0;
    logic [4:0]  gold_wnum = '0;
    logic [31:0] gold_wdata = '0;
    logic [31:0] pass_cnt;
    logic        fail;
    logic        done;
    logic [31:0] err_pc;
    logic [31:0] err_exp_pc;
    logic [4:0]  err_wnum;
    logic [31:0] err_wdata;

    wb_trace_checker #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
        .clk(clk), .reset(reset),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .gold_valid(gold_valid), .gold_ready(gold_ready), .gold_pc(gold_pc),
        .gold_wnum(gold_wnum), .gold_wdata(gold_wdata), .pass_cnt(pass_cnt),
        .fail(fail), .done(done), .err_pc(err_pc), .err_exp_pc(err_exp_pc),
        .err_wnum(err_wnum), .err_wdata(err_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wn;
        logic [31:0] wd;
    } rec_t;

    rec_t        gq[$];
    bit          m_fail, m_pass, m_done;
    logic [31:0] m_cnt, m_err_pc, m_err_exp, m_err_wd;
    logic [4:0]  m_err_wn;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic model_clear();
        gq.delete();
        m_fail = 0; m_pass = 0; m_done = 0;
        m_cnt = 0; m_err_pc = 0; m_err_exp = 0; m_err_wd = 0; m_err_wn = 0;
    endtask

    // Drive one cycle of inputs, advance the model, land #1 after the edge.
    task automatic step(input logic v, input logic [31:0] gpc, input logic [4:0] gwn,
                        input logic [31:0] gwd, input logic [31:0] pc, input logic [3:0] we,
                        input logic [4:0] wn, input logic [31:0] wd);
        int   sz;
        bit   push_ok, ev, bad;
        rec_t h;
        rec_t r;
        logic [31:0] exp_pc;
        gold_valid = v; gold_pc = gpc; gold_wnum = gwn; gold_wdata = gwd;
        debug_wb_pc = pc; debug_wb_rf_we = we; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
        sz      = gq.size();
        push_ok = v && (sz < DEPTH);
        ev      = (we != 4'd0) && (wn != 5'd0);
        if (!m_fail && !m_pass && ev) begin
            bad = 0;
            exp_pc = 32'd0;
            if (sz == 0) begin
                bad = 1;
            end else begin
                h = gq.pop_front();
                exp_pc = h.pc;
                if (h.pc != pc || h.wn != wn) bad = 1;
                for (int i = 0; i < 4; i++)
                    if (we[i] && (h.wd[8*i +: 8] != wd[8*i +: 8])) bad = 1;
            end
            if (bad) begin
                m_fail = 1; m_err_pc = pc; m_err_exp = exp_pc; m_err_wn = wn; m_err_wd = wd;
            end else begin
                m_cnt = m_cnt + 32'd1;
            end
        end
        if (pc == END_PC && !m_pass) begin
            m_done = 1;
            if (!m_fail) m_pass = 1;
        end
        if (push_ok) begin
            r.pc = gpc; r.wn = gwn; r.wd = gwd;
            gq.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, BASE, 4'd0, 5'd0, 0);
    endtask

    task automatic push_rec(input logic [31:0] gpc, input logic [4:0] gwn, input logic [31:0] gwd);
        step(1, gpc, gwn, gwd, BASE, 4'd0, 5'd0, 0);
    endtask

    task automatic ev_only(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wn,
                           input logic [31:0] wd);
        step(0, 0, 0, 0, pc, we, wn, wd);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        gold_valid = 0; debug_wb_rf_we = 0; debug_wb_rf_wnum = 0; debug_wb_pc = BASE;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pass_cnt !== 32'd0) begin n_bad++; $display("FAIL reset pass_cnt got %0d exp 0", pass_cnt); end
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL reset fail got %b exp 0", fail); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset done got %b exp 0", done); end
        n_cmp++; if (gold_ready !== 1'b1) begin n_bad++; $display("FAIL reset gold_ready got %b exp 1", gold_ready); end
        n_cmp++; if ({err_pc, err_exp_pc, err_wnum, err_wdata} !== '0) begin
            n_bad++; $display("FAIL reset err_regs got %h/%h/%h/%h exp 0", err_pc, err_exp_pc, err_wnum, err_wdata);
        end
    endtask

    task automatic test_basic_match();
        do_reset();
        push_rec(32'h1c00_0000, 5'd4, 32'h11);
        push_rec(32'h1c00_0004, 5'd5, 32'h22);
        push_rec(32'h1c00_0008, 5'd6, 32'h33);
        ev_only(32'h1c00_0000, 4'hf, 5'd4, 32'h11);
        ev_only(32'h1c00_0004, 4'hf, 5'd5, 32'h22);
        ev_only(32'h1c00_0008, 4'hf, 5'd6, 32'h33);
        n_cmp++; if (pass_cnt !== 32'd3) begin n_bad++; $display("FAIL basic pass_cnt got %0d exp 3", pass_cnt); end
        n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL basic fail got %b exp 0", fail); end
        // FIFO must now be empty: one more event underflows.
        ev_only(32'h1c00_000c, 4'hf, 5'd8, 32'h44);
        n_cmp++; if (fail !== 1'b1 || err_exp_pc !== 32'd0) begin
            n_bad++; $display("FAIL basic_empty fail/err_exp_pc got %b/%h exp 1/0", fail, err_exp_pc);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        push_rec(32'h1c00_0000, 5'd4, 32'h1234_5678);
        ev_only(32'h1c00_0000, 4'hf, 5'd4, 32'h12FF_5678);
        n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL mismatch fail got %b exp 1", fail); end
        n_cmp++; if (err_pc !== 32'h1c00_0000 || err_exp_pc !== 32'h1c00_0000) begin
            n_bad++; $display("FAIL mismatch err_pc got %h/%h exp 1c000000/1c000000", err_pc, err_exp_pc);
        end
        n_cmp++; if (err_wdata !== 32'h12FF_5678 || err_wnum !== 5'd4) begin
            n_bad++; $display("FAIL mismatch err_data got %h/%0d exp 12ff5678/4", err_wdata, err_wnum);
        end
        n_cmp++; if (pass_cnt !== 32'd0) begin n_bad++; $display("FAIL mismatch pass_cnt got %0d exp 0", pass_cnt); end
    endtask

    task automatic test_masked_match();
        do_reset();
        push_rec(32'h1c00_0000, 5'd4, 32'h1234_5678);
        ev_only(32'h1c00_0000, 4'b0111, 5'd4, 32'hAB34_5678);
        n_cmp++; if (pass_cnt !== 32'd1 || fail !== 1'b0) begin
            n_bad++; $display("FAIL masked pass_cnt/fail got %0d/%b exp 1/0", pass_cnt, fail);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        ev_only(32'h1c00_0010, 4'hf, 5'd7, 32'hdead_beef);
        n_cmp++; if (fail !== 1'b1 || err_exp_pc !== 32'd0 || err_wnum !== 5'd7) begin
            n_bad++; $display("FAIL underflow fail/exp/wnum got %b/%h/%0d exp 1/0/7", fail, err_exp_pc, err_wnum);
        end
        push_rec(32'h1c00_0020, 5'd9, 32'h1);
        ev_only(32'h1c00_0020, 4'hf, 5'd9, 32'h1);
        ev_only(32'h1c00_0030, 4'hf, 5'd3, 32'h5);
        n_cmp++; if (err_pc !== 32'h1c00_0010 || err_wnum !== 5'd7 || err_wdata !== 32'hdead_beef || pass_cnt !== 32'd0) begin
            n_bad++; $display("FAIL underflow_sticky got %h/%0d/%h/%0d exp 1c000010/7/deadbeef/0", err_pc, err_wnum, err_wdata, pass_cnt);
        end
        // FAIL state still accepts pushes up to full (one record already queued).
        for (int i = 0; i < DEPTH - 1; i++) push_rec(BASE + 32'(i * 4), 5'd1, 32'(i));
        n_cmp++; if (gold_ready !== 1'b0) begin n_bad++; $display("FAIL fail_push gold_ready got %b exp 0", gold_ready); end
        ev_only(END_PC, 4'd0, 5'd0, 0);
        n_cmp++; if (done !== 1'b1 || fail !== 1'b1) begin
            n_bad++; $display("FAIL fail_end done/fail got %b/%b exp 1/1", done, fail);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push_rec(BASE + 32'(i * 4), 5'(i + 1), $urandom);
            if (i == DEPTH - 2) begin
                n_cmp++; if (gold_ready !== 1'b1) begin n_bad++; $display("FAIL full_early gold_ready got %b exp 1", gold_ready); end
            end
        end
        n_cmp++; if (gold_ready !== 1'b0) begin n_bad++; $display("FAIL full gold_ready got %b exp 0", gold_ready); end
        step(1, 32'h1c00_00f0, 5'd9, 32'h99, gq[0].pc, 4'hf, gq[0].wn, gq[0].wd);
        n_cmp++; if (gold_ready !== 1'b1 || pass_cnt !== 32'd1) begin
            n_bad++; $display("FAIL full_pop gold_ready/pass_cnt got %b/%0d exp 1/1", gold_ready, pass_cnt);
        end
        // Back-to-back drain; the refused record must not be there afterwards.
        for (int i = 0; i < DEPTH - 1; i++) ev_only(gq[0].pc, 4'hf, gq[0].wn, gq[0].wd);
        n_cmp++; if (pass_cnt !== 32'(DEPTH) || fail !== 1'b0) begin
            n_bad++; $display("FAIL drain pass_cnt/fail got %0d/%b exp %0d/0", pass_cnt, fail, DEPTH);
        end
        ev_only(32'h1c00_00f0, 4'hf, 5'd9, 32'h99);
        n_cmp++; if (fail !== 1'b1 || err_exp_pc !== 32'd0) begin
            n_bad++; $display("FAIL refused_push fail/err_exp_pc got %b/%h exp 1/0", fail, err_exp_pc);
        end
    endtask

    task automatic test_r0_and_end();
        do_reset();
        push_rec(32'h1c00_0040, 5'd2, 32'haaaa_5555);
        ev_only(32'h1c00_0040, 4'hf, 5'd0, 32'h0);
        n_cmp++; if (pass_cnt !== 32'd0 || fail !== 1'b0) begin
            n_bad++; $display("FAIL r0 pass_cnt/fail got %0d/%b exp 0/0", pass_cnt, fail);
        end
        ev_only(32'h1c00_0040, 4'hf, 5'd2, 32'haaaa_5555);
        n_cmp++; if (pass_cnt !== 32'd1) begin n_bad++; $display("FAIL r0_nopop pass_cnt got %0d exp 1", pass_cnt); end
        ev_only(END_PC, 4'd0, 5'd0, 0);
        n_cmp++; if (done !== 1'b1 || fail !== 1'b0) begin
            n_bad++; $display("FAIL end done/fail got %b/%b exp 1/0", done, fail);
        end
        ev_only(32'h1c00_0050, 4'hf, 5'd3, 32'h7);
        n_cmp++; if (fail !== 1'b0 || pass_cnt !== 32'd1) begin
            n_bad++; $display("FAIL pass_terminal fail/pass_cnt got %b/%0d exp 0/1", fail, pass_cnt);
        end
        do_reset();
        n_cmp++; if ({pass_cnt, fail, done, err_pc, err_exp_pc, err_wnum, err_wdata} !== '0 || gold_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_after cnt/fail/done/ready got %0d/%b/%b/%b exp 0/0/0/1", pass_cnt, fail, done, gold_ready);
        end
    endtask

    task automatic test_end_mismatch();
        do_reset();
        push_rec(END_PC, 5'd3, 32'h5);
        ev_only(END_PC, 4'h1, 5'd3, 32'h6);
        n_cmp++; if (fail !== 1'b1 || done !== 1'b1 || err_exp_pc !== END_PC || pass_cnt !== 32'd0) begin
            n_bad++; $display("FAIL end_mismatch fail/done/exp/cnt got %b/%b/%h/%0d exp 1/1/%h/0", fail, done, err_exp_pc, pass_cnt, END_PC);
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [31:0] gpc, gwd, pc, wd;
        logic [4:0]  gwn, wn;
        logic [3:0]  we;
        int          kind;
        for (int round = 0; round < 4; round++) begin
            do_reset();
            for (int cyc = 0; cyc < 80; cyc++) begin
                v   = 1'($urandom_range(0, 1));
                gpc = BASE + 32'($urandom_range(0, 63) * 4);
                gwn = 5'($urandom_range(1, 31));
                gwd = $urandom;
                pc  = BASE + 32'($urandom_range(0, 63) * 4);
                we  = 4'd0; wn = 5'd0; wd = $urandom;
                kind = $urandom_range(0, 199);
                if (kind < 110 && gq.size() > 0) begin
                    pc = gq[0].pc; wn = gq[0].wn; we = 4'($urandom_range(1, 15));
                    for (int i = 0; i < 4; i++) if (we[i]) wd[8*i +: 8] = gq[0].wd[8*i +: 8];
                end else if (kind < 125) begin
                    we = 4'($urandom_range(1, 15));
                end else if (kind < 128) begin
                    we = 4'($urandom_range(1, 15)); wn = 5'($urandom_range(1, 31));
                end else if (kind == 199) begin
                    pc = END_PC;
                end
                step(v, gpc, gwn, gwd, pc, we, wn, wd);
                n_cmp++;
                if (pass_cnt !== m_cnt || fail !== m_fail || done !== m_done ||
                    gold_ready !== (gq.size() < DEPTH) || err_pc !== m_err_pc ||
                    err_exp_pc !== m_err_exp || err_wnum !== m_err_wn || err_wdata !== m_err_wd) begin
                    n_bad++;
                    $display("FAIL random r%0d c%0d got cnt=%0d f=%b d=%b rdy=%b err=%h/%h/%0d/%h exp cnt=%0d f=%b d=%b rdy=%b err=%h/%h/%0d/%h",
                             round, cyc, pass_cnt, fail, done, gold_ready, err_pc, err_exp_pc, err_wnum, err_wdata,
                             m_cnt, m_fail, m_done, (gq.size() < DEPTH), m_err_pc, m_err_exp, m_err_wn, m_err_wd);
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_match();
        test_mismatch();
        test_masked_match();
        test_underflow();
        test_full();
        test_r0_and_end();
        test_end_mismatch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
